id_ex_bubble_ctrl: RTL and testbench
====================================

Name: id_ex_bubble_ctrl

Overview:
- Owns the ID/EX control-word register and decides each cycle whether the decoded control word or the NOP bubble word (from the NOPS generator) enters EX.
- Detects load-use hazards, freezes on memory stalls, and injects a programmable run of bubbles after a taken-branch flush.
- Drives the front-end hold that gates load_pc / load_IF_ID.
- Counts injected bubbles for performance analysis.

Parameters:
- FLUSH_BUBBLES, 2: bubbles injected per flush, including the flush cycle itself; legal range 1..3.
- BUBBLE_CNT_W, 16: width of the saturating bubble counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_ctrl  input  lc3b_control_word  decoded control word of the instruction in ID.
- nop_ctrl  input  lc3b_control_word  bubble word from the NOPS generator.
- id_valid  input  1  ID holds a real instruction.
- id_dest  input  3  destination register of the instruction in ID.
- id_sr1, id_sr2  input  3 each  source registers of the instruction in ID.
- id_uses_sr1, id_uses_sr2  input  1 each  the instruction in ID actually reads that source.
- mem_stall  input  1  memory stage busy; whole pipeline frozen.
- flush  input  1  taken branch resolved; squash younger instructions.
- ex_ctrl  output  lc3b_control_word  registered ID/EX control word.
- ex_dest  output  3  registered destination register for EX.
- hold_front  output  1  combinational; when 1, PC and IF/ID must not load.
- bubble_count  output  BUBBLE_CNT_W  saturating count of injected bubbles.

Behaviour:
- Reset (async, active-high):
  - ex_ctrl = op_nop, aluop alu_add, pcmux_sel 3'b011, all other fields 0.
  - ex_dest = 0, state = RUN, remaining = 0, bubble_count = 0.
  - hold_front is therefore 0.
  - Reset asserted mid-FLUSH or mid-stall aborts to RUN with the values above.
- Hazard: load_use = id_valid & ex_ctrl.mem_read & ex_ctrl.load_regfile & ((id_uses_sr1 & id_sr1==ex_dest) | (id_uses_sr2 & id_sr2==ex_dest)).
- Priority per cycle: mem_stall > flush > load_use > normal.
- mem_stall=1:
  - ex_ctrl, ex_dest, state, remaining and bubble_count all hold.
  - hold_front = 1.
  - A flush asserted during mem_stall is ignored; the upstream unit re-presents it.
- flush=1, no stall:
  - ex_ctrl <= nop_ctrl, ex_dest <= 0.
  - bubble_count increments.
  - If FLUSH_BUBBLES>1: state <= FLUSH, remaining <= FLUSH_BUBBLES-1. Otherwise state stays RUN.
  - hold_front = 0, so fetch redirects.
- FLUSH state, no stall, no new flush:
  - Inject a bubble (same update as above) and decrement remaining.
  - When remaining reaches 0, return to RUN.
  - load_use is ignored (the ID instruction is squashed).
  - hold_front = 0.
  - A new flush in FLUSH restarts remaining at FLUSH_BUBBLES-1.
- RUN with load_use:
  - Inject one bubble and increment bubble_count.
  - hold_front = 1 for that cycle only.
  - The next cycle ex_ctrl is the NOP word, so the hazard clears without extra state.
- RUN normal:
  - id_valid=1: ex_ctrl <= id_ctrl, ex_dest <= id_dest.
  - id_valid=0: ex_ctrl <= nop_ctrl, ex_dest <= 0, not counted as a bubble.
  - hold_front = 0.
- bubble_count saturates at all-ones and never wraps.
- Latency: one cycle from ID inputs to ex_ctrl / ex_dest.

Test Plan:
- Reset check: release reset -> ex_ctrl.opcode=op_nop, pcmux_sel=3'b011, load_regfile=0, bubble_count=0, hold_front=0.
- Load-use: LDR R2 into EX, then ADD R3,R2,R1 in ID (id_sr1=2, id_uses_sr1=1).
  - Expect hold_front=1 for exactly one cycle, ex_ctrl=nop next edge, bubble_count=1.
  - The edge after that, ex_ctrl=ADD word.
  - Repeat with id_uses_sr1=0 -> no bubble.
- Flush with FLUSH_BUBBLES=2: pulse flush one cycle -> two consecutive NOP words in ex_ctrl, bubble_count=2, hold_front=0 throughout, then id_ctrl resumes.
  - Re-pulse flush during the 2nd bubble -> three total bubbles.
- mem_stall for 4 cycles with a hazard and a flush asserted simultaneously -> ex_ctrl/ex_dest/bubble_count unchanged, hold_front=1 all 4 cycles.
  - After release, the load-use bubble is taken (flush was dropped).
- Saturation with BUBBLE_CNT_W=3: inject 9 bubbles -> bubble_count stays 7.
- Reset during FLUSH: assert reset asynchronously mid-clock -> outputs go to reset values immediately, and the state is RUN after release.

Source files
------------

// File: rtl/id_ex_bubble_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lc3b_types_pkg / id_ex_bubble_ctrl_if                           |
// | Purpose  : LC-3b control-word types and the ID/EX bubble-control bundle.   |
// |            master = pipeline side (drives ID info, stall, flush)           |
// |            slave  = id_ex_bubble_ctrl (drives EX word, hold, counter)      |
// | Ports    : id_ctrl, nop_ctrl, id_valid, id_dest, id_sr1, id_sr2,           |
// |            id_uses_sr1, id_uses_sr2, mem_stall, flush (to slave);          |
// |            ex_ctrl, ex_dest, hold_front, bubble_count (from slave)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lc3b_types_pkg;

  // op_nop shares the BR encoding: BR with nzp=000 never branches.
  typedef enum logic [3:0] {
    op_nop  = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic [2:0] pcmux_sel;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       load_cc;
  } lc3b_control_word;

endpackage

interface id_ex_bubble_ctrl_if #(
  parameter int BUBBLE_CNT_W = 16
);
  lc3b_types_pkg::lc3b_control_word id_ctrl;
  lc3b_types_pkg::lc3b_control_word nop_ctrl;
  logic                             id_valid;
  logic [2:0]                       id_dest;
  logic [2:0]                       id_sr1;
  logic [2:0]                       id_sr2;
  logic                             id_uses_sr1;
  logic                             id_uses_sr2;
  logic                             mem_stall;
  logic                             flush;
  lc3b_types_pkg::lc3b_control_word ex_ctrl;
  logic [2:0]                       ex_dest;
  logic                             hold_front;
  logic [BUBBLE_CNT_W-1:0]          bubble_count;

  modport master (
    output id_ctrl, nop_ctrl, id_valid, id_dest, id_sr1, id_sr2,
           id_uses_sr1, id_uses_sr2, mem_stall, flush,
    input  ex_ctrl, ex_dest, hold_front, bubble_count
  );

  modport slave (
    input  id_ctrl, nop_ctrl, id_valid, id_dest, id_sr1, id_sr2,
           id_uses_sr1, id_uses_sr2, mem_stall, flush,
    output ex_ctrl, ex_dest, hold_front, bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_bubble_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_ex_bubble_ctrl                                               |
// | Purpose  : Owns the ID/EX control-word register. Each cycle selects the    |
// |            decoded word or the NOP bubble word, detects load-use hazards,  |
// |            freezes on memory stalls, injects FLUSH_BUBBLES bubbles after a |
// |            taken-branch flush and counts injected bubbles (saturating).    |
// | Ports    : clk   - pipeline clock, rising edge                             |
// |            reset - asynchronous, active-high reset                         |
// |            bus   - id_ex_bubble_ctrl_if.slave (ID info in; EX word,        |
// |                    hold_front and bubble_count out)                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module id_ex_bubble_ctrl #(
  parameter int FLUSH_BUBBLES = 2,   // legal 1..3, includes the flush cycle
  parameter int BUBBLE_CNT_W  = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  id_ex_bubble_ctrl_if.slave bus
);
  import lc3b_types_pkg::*;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam lc3b_control_word RESET_WORD = '{
    opcode:       op_nop,
    aluop:        alu_add,
    pcmux_sel:    3'b011,
    load_regfile: 1'b0,
    mem_read:     1'b0,
    mem_write:    1'b0,
    load_cc:      1'b0
  };

  // Bubbles still owed after the flush cycle itself.
  localparam logic [1:0] FLUSH_REM = 2'(FLUSH_BUBBLES - 1);

  state_t                  state_q, state_d;
  logic [1:0]              remaining_q, remaining_d;
  lc3b_control_word        ex_ctrl_q, ex_ctrl_d;
  logic [2:0]              ex_dest_q, ex_dest_d;
  logic [BUBBLE_CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic                    bubble_inj;
  logic                    hold_front;
  logic                    load_use;

  // Only a load (mem_read with a register write) creates the hazard; the
  // source must actually be read by the ID instruction to matter.
  assign load_use = bus.id_valid & ex_ctrl_q.mem_read & ex_ctrl_q.load_regfile &
                    ((bus.id_uses_sr1 & (bus.id_sr1 == ex_dest_q)) |
                     (bus.id_uses_sr2 & (bus.id_sr2 == ex_dest_q)));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_dest_d   = ex_dest_q;
    bubble_inj  = 1'b0;
    hold_front  = 1'b0;

    if (bus.mem_stall) begin
      // Whole pipe frozen; any flush seen now is re-presented later.
      hold_front = 1'b1;
    end else if (bus.flush) begin
      ex_ctrl_d  = bus.nop_ctrl;
      ex_dest_d  = 3'd0;
      bubble_inj = 1'b1;
      if (FLUSH_BUBBLES > 1) begin
        state_d     = ST_FLUSH;
        remaining_d = FLUSH_REM;
      end else begin
        state_d     = ST_RUN;
        remaining_d = 2'd0;
      end
    end else if (state_q == ST_FLUSH) begin
      // ID holds a squashed instruction, so load_use is irrelevant here.
      ex_ctrl_d   = bus.nop_ctrl;
      ex_dest_d   = 3'd0;
      bubble_inj  = 1'b1;
      remaining_d = remaining_q - 2'd1;
      if (remaining_q <= 2'd1) begin
        state_d     = ST_RUN;
        remaining_d = 2'd0;
      end
    end else if (load_use) begin
      // Next cycle EX holds the NOP word, so the hazard clears by itself.
      ex_ctrl_d  = bus.nop_ctrl;
      ex_dest_d  = 3'd0;
      bubble_inj = 1'b1;
      hold_front = 1'b1;
    end else if (bus.id_valid) begin
      ex_ctrl_d = bus.id_ctrl;
      ex_dest_d = bus.id_dest;
    end else begin
      ex_ctrl_d = bus.nop_ctrl;
      ex_dest_d = 3'd0;
    end

    bubble_count_d = bubble_count_q;
    if (bubble_inj && (bubble_count_q != {BUBBLE_CNT_W{1'b1}})) begin
      bubble_count_d = bubble_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      remaining_q    <= 2'd0;
      ex_ctrl_q      <= RESET_WORD;
      ex_dest_q      <= 3'd0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_dest_q      <= ex_dest_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.hold_front   = hold_front;
  assign bus.bubble_count = bubble_count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_bubble_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_id_ex_bubble_ctrl                                            |
// | Purpose  : Table-driven bench for id_ex_bubble_ctrl (FLUSH_BUBBLES=2,      |
// |            BUBBLE_CNT_W=3) with a queue of expected EX results.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_id_ex_bubble_ctrl;
  import lc3b_types_pkg::*;

  localparam int CNT_W = 3;
  localparam int C_NOP = 0;
  localparam int C_ADD = 1;
  localparam int C_LDR = 2;

  logic clk;
  logic reset;

  id_ex_bubble_ctrl_if #(.BUBBLE_CNT_W(CNT_W)) bus ();

  id_ex_bubble_ctrl #(
    .FLUSH_BUBBLES(2),
    .BUBBLE_CNT_W (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         valid;
    int         id_code;
    logic [2:0] dest;
    logic [2:0] sr1;
    logic [2:0] sr2;
    bit         u1;
    bit         u2;
    bit         stall;
    bit         flush;
    bit         exp_hold;
    int         exp_code;
    logic [2:0] exp_dest;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic lc3b_control_word word(int c);
    lc3b_control_word w;
    w = '{opcode: op_nop, aluop: alu_add, pcmux_sel: 3'b011, load_regfile: 1'b0,
          mem_read: 1'b0, mem_write: 1'b0, load_cc: 1'b0};
    if (c == C_ADD) begin
      w = '{opcode: op_add, aluop: alu_add, pcmux_sel: 3'b000, load_regfile: 1'b1,
            mem_read: 1'b0, mem_write: 1'b0, load_cc: 1'b1};
    end else if (c == C_LDR) begin
      w = '{opcode: op_ldr, aluop: alu_add, pcmux_sel: 3'b000, load_regfile: 1'b1,
            mem_read: 1'b1, mem_write: 1'b0, load_cc: 1'b1};
    end
    return w;
  endfunction

  function automatic void add(string name, bit valid, int code, logic [2:0] dest,
                              logic [2:0] sr1, bit u1, logic [2:0] sr2, bit u2,
                              bit stall, bit flush, bit e_hold, int e_code,
                              logic [2:0] e_dest, logic [2:0] e_cnt);
    vec_t v;
    v.name = name; v.valid = valid; v.id_code = code; v.dest = dest;
    v.sr1 = sr1; v.u1 = u1; v.sr2 = sr2; v.u2 = u2;
    v.stall = stall; v.flush = flush; v.exp_hold = e_hold;
    v.exp_code = e_code; v.exp_dest = e_dest; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.id_valid    = v.valid;
    bus.id_ctrl     = word(v.id_code);
    bus.id_dest     = v.dest;
    bus.id_sr1      = v.sr1;
    bus.id_sr2      = v.sr2;
    bus.id_uses_sr1 = v.u1;
    bus.id_uses_sr2 = v.u2;
    bus.mem_stall   = v.stall;
    bus.flush       = v.flush;
  endtask

  task automatic check_ex();
    vec_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'(word(e.exp_code)));
      check({e.name, " ex_dest"}, 32'(bus.ex_dest), 32'(e.exp_dest));
      check({e.name, " count"},   32'(bus.bubble_count), 32'(e.exp_cnt));
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    #1;
    check({v.name, " hold"}, 32'(bus.hold_front), 32'(v.exp_hold));
    @(posedge clk);
    #1;
    check_ex();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // name, valid, code, dest, sr1, u1, sr2, u2, stall, flush | hold, ex code, ex dest, cnt
    add("ldr_r2",       1, C_LDR, 3'd2, 3'd3, 1, 3'd0, 0, 0, 0,  0, C_LDR, 3'd2, 3'd0);
    add("lu_sr1",       1, C_ADD, 3'd3, 3'd2, 1, 3'd1, 1, 0, 0,  1, C_NOP, 3'd0, 3'd1);
    add("lu_resume",    1, C_ADD, 3'd3, 3'd2, 1, 3'd1, 1, 0, 0,  0, C_ADD, 3'd3, 3'd1);
    add("ldr_r2_b",     1, C_LDR, 3'd2, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_LDR, 3'd2, 3'd1);
    add("no_use_sr1",   1, C_ADD, 3'd3, 3'd2, 0, 3'd1, 1, 0, 0,  0, C_ADD, 3'd3, 3'd1);
    add("ldr_r5",       1, C_LDR, 3'd5, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_LDR, 3'd5, 3'd1);
    add("lu_sr2",       1, C_ADD, 3'd3, 3'd0, 1, 3'd5, 1, 0, 0,  1, C_NOP, 3'd0, 3'd2);
    add("invalid_id",   0, C_ADD, 3'd6, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_NOP, 3'd0, 3'd2);
    add("ldr_r4",       1, C_LDR, 3'd4, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_LDR, 3'd4, 3'd2);
    add("lu_invalid",   0, C_ADD, 3'd3, 3'd4, 1, 3'd0, 0, 0, 0,  0, C_NOP, 3'd0, 3'd2);
    add("flush_1",      1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 1,  0, C_NOP, 3'd0, 3'd3);
    add("flush_2",      1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_NOP, 3'd0, 3'd4);
    add("flush_done",   1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_ADD, 3'd3, 3'd4);
    add("ldr_pre_stl",  1, C_LDR, 3'd2, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_LDR, 3'd2, 3'd4);
    for (int i = 0; i < 4; i++)
      add("stall",      1, C_ADD, 3'd3, 3'd2, 1, 3'd0, 0, 1, 1,  1, C_LDR, 3'd2, 3'd4);
    add("post_stl_lu",  1, C_ADD, 3'd3, 3'd2, 1, 3'd0, 0, 0, 0,  1, C_NOP, 3'd0, 3'd5);
    add("post_stl_add", 1, C_ADD, 3'd3, 3'd2, 1, 3'd0, 0, 0, 0,  0, C_ADD, 3'd3, 3'd5);
    add("reflush_1",    1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 1,  0, C_NOP, 3'd0, 3'd6);
    add("reflush_2",    1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 1,  0, C_NOP, 3'd0, 3'd7);
    add("reflush_3",    1, C_ADD, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_NOP, 3'd0, 3'd7);
    add("reflush_done", 1, C_ADD, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_ADD, 3'd1, 3'd7);
    add("sat_flush_1",  1, C_ADD, 3'd1, 3'd0, 0, 3'd0, 0, 0, 1,  0, C_NOP, 3'd0, 3'd7);
    add("sat_flush_2",  1, C_ADD, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_NOP, 3'd0, 3'd7);
    add("sat_ldr_r6",   1, C_LDR, 3'd6, 3'd0, 0, 3'd0, 0, 0, 0,  0, C_LDR, 3'd6, 3'd7);
    add("sat_lu",       1, C_ADD, 3'd1, 3'd0, 0, 3'd6, 1, 0, 0,  1, C_NOP, 3'd0, 3'd7);
    add("sat_add",      1, C_ADD, 3'd1, 3'd0, 0, 3'd6, 1, 0, 0,  0, C_ADD, 3'd1, 3'd7);

    // Reset and idle inputs.
    bus.nop_ctrl = word(C_NOP);
    v = vecs[0];
    v.valid = 0; v.stall = 0; v.flush = 0;
    drive(v);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset ex_ctrl", 32'(bus.ex_ctrl), 32'(word(C_NOP)));
    check("reset ex_dest", 32'(bus.ex_dest), 32'd0);
    check("reset count",   32'(bus.bubble_count), 32'd0);
    check("reset hold",    32'(bus.hold_front), 32'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted mid-cycle while in FLUSH aborts to RUN.
    v = vecs[0];
    v.name = "rst_flush"; v.valid = 1; v.id_code = C_ADD; v.dest = 3'd3;
    v.u1 = 0; v.u2 = 0; v.stall = 0; v.flush = 1;
    v.exp_hold = 0; v.exp_code = C_NOP; v.exp_dest = 3'd0; v.exp_cnt = 3'd7;
    apply(v);
    @(negedge clk);
    v.flush = 0;
    drive(v);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst ex_ctrl", 32'(bus.ex_ctrl), 32'(word(C_NOP)));
    check("async_rst ex_dest", 32'(bus.ex_dest), 32'd0);
    check("async_rst count",   32'(bus.bubble_count), 32'd0);
    check("async_rst hold",    32'(bus.hold_front), 32'd0);
    v.name = "after_rst"; v.exp_code = C_ADD; v.exp_dest = 3'd3; v.exp_cnt = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    apply(v);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
